// File: rtl/lvds_s2p_frame.sv
// Serial-to-parallel frame capture: packs LANES bits/clock into DATA_W words, replays them as a burst after the frame ends.
// Latency: first dout_vld 3 clocks after the first din_vld=0 sample (1 decision clock + 2 DRAIN clocks).
// Backpressure: none. Input bits are never stalled and the consumer must accept every dout_vld word.
//
// Ports:
//   clk, rst_n       sole clock (rising edge), asynchronous active-low reset
//   din_vld, din     frame-valid flag and LANES serial bits (din[0] earliest)
//   dout, dout_vld   packed output word and its qualifier
//   dout_sop/eop     first/last word of a replayed burst
//   frame_len        bit count of the last accepted frame
//   frame_drop       one-clock pulse per rejected frame
//   busy             high while capturing or draining
//
// Optional: define LVDS_S2P_STATS_EN to add saturating frame_cnt/drop_cnt outputs.
// Legal configurations: LANES in {1,2,4}, DATA_W a multiple of LANES.

module lvds_s2p_frame #(
  parameter int LANES     = 1,
  parameter int DATA_W    = 8,
  parameter int DEPTH_W   = 14,
  parameter int HDR_WORDS = 14,
  parameter int MIN_WORDS = 6,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_vld,
  input  logic [LANES-1:0]   din,
  output logic [DATA_W-1:0]  dout,
  output logic               dout_vld,
  output logic               dout_sop,
  output logic               dout_eop,
  output logic [DEPTH_W:0]   frame_len,
  output logic               frame_drop,
  output logic               busy
`ifdef LVDS_S2P_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  // Counter widths: bit/word counters must be able to hold 2^DEPTH_W itself.
  localparam int CW      = DEPTH_W + 1;
  localparam int WORDS_N = (1 << DEPTH_W) / DATA_W;
  localparam int AW      = (WORDS_N > 1) ? $clog2(WORDS_N) : 1;
  localparam int SW      = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] MAX_BITS = CW'(1 << DEPTH_W);
  localparam logic [CW-1:0] LANES_C  = CW'(LANES);
  localparam logic [CW-1:0] HDR_C    = CW'(HDR_WORDS);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_WORDS);
  localparam logic [SW-1:0] LANES_S  = SW'(LANES);
  localparam logic [SW-1:0] DATA_S   = SW'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_armed;
  logic [CW-1:0]       r_bit_cnt;
  logic [CW-1:0]       r_wcnt;
  logic [CW-1:0]       r_raddr;
  logic [SW-1:0]       r_sub;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_pack;
  logic [DATA_W-1:0]   r_mem [WORDS_N];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rd_vld;
  logic                r_rd_first;
  logic                r_rd_last;

  logic [DATA_W-1:0]   w_pack_nxt;
  logic                w_accept;
  logic                w_word_done;
  logic                w_decide;
  logic                w_keep;
  logic                w_rd_issue;

  // Bits are taken in IDLE only on a fresh rising edge of din_vld (armed),
  // and in CAPTURE until the buffer is full; later bits of an overlong frame are ignored.
  assign w_accept    = din_vld &&
                       (((r_state == S_IDLE) && r_armed) ||
                        ((r_state == S_CAPTURE) && (r_bit_cnt != MAX_BITS)));
  assign w_word_done = w_accept && ((r_sub + LANES_S) == DATA_S);

  // End of frame: the first din_vld=0 clock seen while capturing.
  assign w_decide    = (r_state == S_CAPTURE) && !din_vld;
  assign w_keep      = !r_ovf && (r_wcnt >= MIN_C) && (r_wcnt > HDR_C);

  // Header words are skipped simply by starting the read pointer at HDR_WORDS.
  assign w_rd_issue  = (r_state == S_DRAIN) && (r_raddr < r_wcnt);

  assign busy        = (r_state != S_IDLE);

  // Next pack value. MSB-first shifts left so the oldest bit climbs toward the MSB;
  // LSB-first shifts right so the oldest bit ends up at bit 0.
  always_comb begin
    w_pack_nxt = '0;
    if (MSB_FIRST != 0) begin
      w_pack_nxt = r_pack << LANES;
      for (int i = 0; i < LANES; i++) begin
        w_pack_nxt[LANES-1-i] = din[i];
      end
    end else begin
      w_pack_nxt = r_pack >> LANES;
      for (int i = 0; i < LANES; i++) begin
        w_pack_nxt[DATA_W-LANES+i] = din[i];
      end
    end
  end

  // Frame buffer: synchronous write, registered read (1-clock read latency), no reset.
  always_ff @(posedge clk) begin
    if (w_word_done) begin
      r_mem[r_wcnt[AW-1:0]] <= w_pack_nxt;
    end
    r_rdata <= r_mem[r_raddr[AW-1:0]];
  end

  // Control FSM, capture counters, read pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_bit_cnt  <= '0;
      r_wcnt     <= '0;
      r_raddr    <= '0;
      r_sub      <= '0;
      r_ovf      <= 1'b0;
      r_pack     <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      frame_len  <= '0;
      frame_drop <= 1'b0;
    end else begin
      // Armed means the previous sample of din_vld was low, so only a
      // 0->1 edge observed in IDLE can start a capture. This also keeps a
      // frame that began during DRAIN (or before reset release) out.
      r_armed    <= !din_vld;

      frame_drop <= 1'b0;
      dout_vld   <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;

      // Read pipeline: address issue -> RAM data -> output register.
      r_rd_vld   <= w_rd_issue;
      r_rd_first <= w_rd_issue && (r_raddr == HDR_C);
      r_rd_last  <= w_rd_issue && (r_raddr == (r_wcnt - 1'b1));
      if (r_rd_vld) begin
        dout     <= r_rdata;
        dout_vld <= 1'b1;
        dout_sop <= r_rd_first;
        dout_eop <= r_rd_last;
      end

      if (w_accept) begin
        r_pack    <= w_pack_nxt;
        r_bit_cnt <= r_bit_cnt + LANES_C;
        if (w_word_done) begin
          r_sub  <= '0;
          r_wcnt <= r_wcnt + 1'b1;
        end else begin
          r_sub  <= r_sub + LANES_S;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (w_decide) begin
            if (w_keep) begin
              frame_len <= r_bit_cnt;
              r_raddr   <= HDR_C;
              r_state   <= S_DRAIN;
            end else begin
              // Rejected frame: counters are cleared here so the next
              // capture can start in the very next IDLE clock.
              frame_drop <= 1'b1;
              r_bit_cnt  <= '0;
              r_wcnt     <= '0;
              r_sub      <= '0;
              r_ovf      <= 1'b0;
              r_state    <= S_IDLE;
            end
          end else if (r_bit_cnt == MAX_BITS) begin
            r_ovf <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (w_rd_issue) begin
            r_raddr <= r_raddr + 1'b1;
          end
          // r_wcnt bounds the read loop, so it is only cleared once the EOP
          // word is on the output.
          if (dout_eop) begin
            r_bit_cnt <= '0;
            r_wcnt    <= '0;
            r_sub     <= '0;
            r_ovf     <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LVDS_S2P_STATS_EN
  // Saturating frame statistics: accepted frames counted on DRAIN entry,
  // rejected frames counted on each frame_drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (w_decide && w_keep && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (frame_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lvds_s2p_frame.sv
// Bench for lvds_s2p_frame: four configurations driven with directed frames.
// Latency: n/a.
// Backpressure: n/a.

module tb_lvds_s2p_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv   [4];
  logic [3:0]  dn   [4];
  logic [7:0]  o_d  [4];
  logic        o_v  [4];
  logic        o_s  [4];
  logic        o_e  [4];
  logic        o_drop [4];
  logic        o_busy [4];
  logic [14:0] len0, len1, len2;
  logic [8:0]  len3;
`ifdef LVDS_S2P_STATS_EN
  logic [15:0] fc [4];
  logic [15:0] dc [4];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // u0: defaults. u1/u2: 4 lanes, no header, MSB/LSB first. u3: 256-bit buffer.
  lvds_s2p_frame u0 (
    .clk(clk), .rst_n(rst_n), .din_vld(dv[0]), .din(dn[0][0:0]),
    .dout(o_d[0]), .dout_vld(o_v[0]), .dout_sop(o_s[0]), .dout_eop(o_e[0]),
    .frame_len(len0), .frame_drop(o_drop[0]), .busy(o_busy[0])
`ifdef LVDS_S2P_STATS_EN
    , .frame_cnt(fc[0]), .drop_cnt(dc[0])
`endif
  );

  lvds_s2p_frame #(.LANES(4), .HDR_WORDS(0), .MIN_WORDS(6), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din_vld(dv[1]), .din(dn[1]),
    .dout(o_d[1]), .dout_vld(o_v[1]), .dout_sop(o_s[1]), .dout_eop(o_e[1]),
    .frame_len(len1), .frame_drop(o_drop[1]), .busy(o_busy[1])
`ifdef LVDS_S2P_STATS_EN
    , .frame_cnt(fc[1]), .drop_cnt(dc[1])
`endif
  );

  lvds_s2p_frame #(.LANES(4), .HDR_WORDS(0), .MIN_WORDS(6), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst_n(rst_n), .din_vld(dv[2]), .din(dn[2]),
    .dout(o_d[2]), .dout_vld(o_v[2]), .dout_sop(o_s[2]), .dout_eop(o_e[2]),
    .frame_len(len2), .frame_drop(o_drop[2]), .busy(o_busy[2])
`ifdef LVDS_S2P_STATS_EN
    , .frame_cnt(fc[2]), .drop_cnt(dc[2])
`endif
  );

  lvds_s2p_frame #(.DEPTH_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .din_vld(dv[3]), .din(dn[3][0:0]),
    .dout(o_d[3]), .dout_vld(o_v[3]), .dout_sop(o_s[3]), .dout_eop(o_e[3]),
    .frame_len(len3), .frame_drop(o_drop[3]), .busy(o_busy[3])
`ifdef LVDS_S2P_STATS_EN
    , .frame_cnt(fc[3]), .drop_cnt(dc[3])
`endif
  );

  typedef struct {
    int         k;          // instance
    int         nbits;      // bits sent while din_vld=1
    int         lanes;
    int         base;       // byte j of the frame is base+j, sent MSB bit first
    int         n;          // expected output words
    logic [7:0] first_byte; // source byte behind the first output word
    logic [7:0] last_word;  // expected dout of the EOP word
    bit         rev;        // output is bit-reversed source byte
    bit         drop;       // expect one frame_drop pulse
    int         len;        // expected frame_len afterwards
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] get_len(input int k);
    case (k)
      0:       return {17'd0, len0};
      1:       return {17'd0, len1};
      2:       return {17'd0, len2};
      default: return {23'd0, len3};
    endcase
  endfunction

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic bitval(input int base, input int n);
    logic [7:0] b;
    b = 8'(base + n / 8);
    return b[7 - (n % 8)];
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d: got 0x%0h want 0x%0h", nm, k, got, exp);
    end
  endtask

  task automatic send_bits(input int k, input int nbits, input int base, input int lanes);
    for (int c = 0; c < nbits / lanes; c++) begin
      @(posedge clk); #1;
      dv[k] = 1'b1;
      for (int i = 0; i < lanes; i++) dn[k][i] = bitval(base, c * lanes + i);
    end
    @(posedge clk); #1;
    dv[k] = 1'b0;
    dn[k] = '0;
  endtask

  // Called right after din_vld falls; clock c=1 is the negedge after the decision edge.
  task automatic observe(input vec_t v);
    int cnt, drops, lat, dropc;
    bit prev_eop;
    logic [7:0] b, e;
    cnt = 0; drops = 0; lat = -1; dropc = -1; prev_eop = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (prev_eop) chk("busy_after_eop", v.k, {31'd0, o_busy[v.k]}, 0);
      prev_eop = 1'b0;
      if (o_drop[v.k]) begin
        drops++;
        if (dropc < 0) dropc = c;
      end
      if (o_v[v.k]) begin
        if (lat < 0) lat = c;
        b = 8'(v.first_byte + cnt);
        e = v.rev ? bitrev(b) : b;
        chk("word", v.k, {24'd0, o_d[v.k]}, {24'd0, e});
        chk("sop", v.k, {31'd0, o_s[v.k]}, {31'd0, cnt == 0});
        chk("eop", v.k, {31'd0, o_e[v.k]}, {31'd0, cnt == v.n - 1});
        if (cnt == v.n - 1) chk("last_word", v.k, {24'd0, o_d[v.k]}, {24'd0, v.last_word});
        if (o_e[v.k]) begin
          chk("busy_at_eop", v.k, {31'd0, o_busy[v.k]}, 1);
          prev_eop = 1'b1;
        end
        cnt++;
      end
    end
    chk("word_count", v.k, cnt, v.n);
    chk("drop_count", v.k, drops, {31'd0, v.drop});
    if (v.n > 0) chk("first_vld_latency", v.k, lat, 3);
    if (v.drop) chk("drop_cycle", v.k, dropc, 1);
    chk("frame_len", v.k, get_len(v.k), v.len);
  endtask

  task automatic chk_zero(input int k, input string nm);
    chk({nm, "_dout"}, k, {24'd0, o_d[k]}, 0);
    chk({nm, "_vld"},  k, {31'd0, o_v[k]}, 0);
    chk({nm, "_sop"},  k, {31'd0, o_s[k]}, 0);
    chk({nm, "_eop"},  k, {31'd0, o_e[k]}, 0);
    chk({nm, "_drop"}, k, {31'd0, o_drop[k]}, 0);
    chk({nm, "_busy"}, k, {31'd0, o_busy[k]}, 0);
    chk({nm, "_len"},  k, get_len(k), 0);
`ifdef LVDS_S2P_STATS_EN
    chk({nm, "_fcnt"}, k, {16'd0, fc[k]}, 0);
    chk({nm, "_dcnt"}, k, {16'd0, dc[k]}, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   seen;

    //         k nbits ln base  n  first  last   rev drop len
    vecs[0] = '{0, 200, 1, 8'h00, 11, 8'h0E, 8'h18, 0, 0, 200}; // 25 words, 14 header
    vecs[1] = '{0, 120, 1, 8'h00,  1, 8'h0E, 8'h0E, 0, 0, 120}; // single word sop=eop
    vecs[2] = '{0, 100, 1, 8'h00,  0, 8'h00, 8'h00, 0, 1, 120}; // 12 words <= header
    vecs[3] = '{0, 112, 1, 8'h00,  0, 8'h00, 8'h00, 0, 1, 120}; // exactly HDR_WORDS
    vecs[4] = '{1,  52, 4, 8'h31,  6, 8'h31, 8'h36, 0, 0,  52}; // trailing nibble dropped
    vecs[5] = '{2,  52, 4, 8'h31,  6, 8'h31, 8'h6C, 1, 0,  52}; // LSB-first: reversed
    vecs[6] = '{1,  44, 4, 8'h31,  0, 8'h00, 8'h00, 0, 1,  52}; // 5 words < MIN_WORDS
    vecs[7] = '{1,  48, 4, 8'hC0,  6, 8'hC0, 8'hC5, 0, 0,  48}; // exactly MIN_WORDS
    vecs[8] = '{3, 300, 1, 8'h00,  0, 8'h00, 8'h00, 0, 1,   0}; // overflow past 256 bits
    vecs[9] = '{3, 256, 1, 8'h00, 18, 8'h0E, 8'h1F, 0, 0, 256}; // exactly full buffer

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      dn[k] = '0;
    end
    // A frame already running when reset is released must be ignored.
    dv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk_zero(k, "reset");
    rst_n = 1'b1;
    send_bits(0, 200, 8'h80, 1);
    observe('{0, 200, 1, 8'h80, 0, 8'h00, 8'h00, 0, 0, 0});

    for (int t = 0; t < 10; t++) begin
      send_bits(vecs[t].k, vecs[t].nbits, vecs[t].base, vecs[t].lanes);
      observe(vecs[t]);
    end

    // A frame that starts during DRAIN is ignored, even after DRAIN ends.
    send_bits(0, 200, 8'h00, 1);
    fork
      observe(vecs[0]);
      begin
        repeat (2) @(posedge clk);
        send_bits(0, 320, 8'h55, 1);
      end
    join
    observe('{0, 320, 1, 8'h55, 0, 8'h00, 8'h00, 0, 0, 200});

    // Reset in the middle of a burst clears every output at once, no EOP follows.
    send_bits(0, 200, 8'h40, 1);
    seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      @(negedge clk);
      if (o_v[0]) seen++;
    end
    chk("drain_reached", 0, seen, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "mid_drain_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    observe('{0, 200, 1, 8'h40, 0, 8'h00, 8'h00, 0, 0, 0});

`ifdef LVDS_S2P_STATS_EN
    for (int f = 0; f < 5; f++) begin
      if (f % 2 == 0) begin
        send_bits(0, 120, 8'h00, 1);
        observe(vecs[1]);
      end else begin
        send_bits(0, 100, 8'h00, 1);
        observe(vecs[2]);
      end
    end
    chk("frame_cnt", 0, {16'd0, fc[0]}, 3);
    chk("drop_cnt",  0, {16'd0, dc[0]}, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
